// File: rtl/param_input_wrapper.sv
// Gathers NWORDS input words of DW bits into one frame, then hands the frame
// downstream with a one-cycle start pulse once the previous frame was consumed.
module param_input_wrapper #(
  parameter int DW           = 8,
  parameter int NWORDS       = 4,
  parameter int WAIT_RELEASE = 1,
  localparam int CW          = ($clog2(NWORDS) < 1) ? 1 : $clog2(NWORDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 input_rdy,
  input  logic [DW-1:0]        data_in,
  input  logic                 outsent,
  output logic                 input_acc,
  output logic                 start,
  output logic [NWORDS*DW-1:0] data_out,
  output logic [CW-1:0]        word_cnt,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_RELEASE  = 3'd2,
    S_WAIT_BUF = 3'd3,
    S_START    = 3'd4
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

  state_t                          state;
  logic                            sent_ok;
  logic                            xfer;
  logic [NWORDS-1:0][DW-1:0]       frame;

  assign input_acc = (state == S_LOAD);
  assign start     = (state == S_START);
  assign busy      = (state != S_IDLE);
  assign xfer      = input_acc & input_rdy;
  assign data_out  = frame;

  // One write-enabled register per slot; only the slot under word_cnt moves.
  for (genvar k = 0; k < NWORDS; k++) begin : g_slot
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        frame[k] <= '0;
      else if (xfer && (word_cnt == CW'(k)))
        frame[k] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      word_cnt <= '0;
      sent_ok  <= 1'b1;
    end else begin
      // outsent wins over the clear taken while presenting a frame
      if (outsent)
        sent_ok <= 1'b1;
      else if (state == S_START)
        sent_ok <= 1'b0;

      case (state)
        S_IDLE: begin
          word_cnt <= '0;
          if (input_rdy) state <= S_LOAD;
        end
        S_LOAD: begin
          if (input_rdy) begin
            if (word_cnt == LAST) begin
              word_cnt <= '0;
              state    <= (WAIT_RELEASE != 0) ? S_RELEASE : S_WAIT_BUF;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        S_RELEASE:  if (!input_rdy) state <= S_WAIT_BUF;
        S_WAIT_BUF: if (sent_ok || outsent) state <= S_START;
        S_START:    state <= S_IDLE;
        default: begin
          state    <= S_IDLE;
          word_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_input_wrapper.sv
// Directed frames into param_input_wrapper; a monitor checks every start pulse
// against a queue of hand-computed frames pushed by the stimulus.
module tb_param_input_wrapper;
  localparam int DW = 8;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          input_rdy = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          outsent = 1'b0;
  logic          input_acc, start, busy;
  logic [NW*DW-1:0] data_out;
  logic [1:0]    word_cnt;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  int acc_cnt = 0;
  logic [NW*DW-1:0] exp_q[$];

  param_input_wrapper #(.DW(DW), .NWORDS(NW), .WAIT_RELEASE(1)) dut (
    .clk(clk), .rst(rst), .input_rdy(input_rdy), .data_in(data_in),
    .outsent(outsent), .input_acc(input_acc), .start(start),
    .data_out(data_out), .word_cnt(word_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: every start pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (rst && input_acc) acc_cnt++;
    if (rst && start) begin
      start_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_start", 64'(data_out), 64'hDEAD);
      end else begin
        chk("frame", 64'(data_out), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic push_word(input logic [DW-1:0] w);
    logic acc;
    int n;
    input_rdy = 1'b1;
    data_in   = w;
    n = 0;
    do begin
      @(negedge clk);
      acc = input_acc;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 20);
    if (!acc) chk("push_timeout", 64'(n), 64'(0));
  endtask

  task automatic wait_start();
    int s0;
    s0 = start_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (start_cnt != s0) return;
    end
    chk("start_timeout", 64'(start_cnt), 64'(s0 + 1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a0;
    // Reset state
    #3;
    chk("rst_acc", 64'(input_acc), 0);
    chk("rst_start", 64'(start), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_cnt", 64'(word_cnt), 0);
    chk("rst_data", 64'(data_out), 0);
    tick();
    rst = 1'b1;

    // Frame 1: continuous input, no outsent needed after reset
    a0 = acc_cnt;
    exp_q.push_back(32'h44332211);
    push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
    input_rdy = 1'b0;
    wait_start();
    repeat (3) tick();
    chk("f1_starts", 64'(start_cnt), 1);
    chk("f1_acc_cycles", 64'(acc_cnt - a0), 4);

    // Frame 2: stall between words, then park in WAIT_BUF without outsent
    exp_q.push_back(32'h04030201);
    push_word(8'h01);
    input_rdy = 1'b0; data_in = 8'hEE; tick();
    chk("stall_cnt1", 64'(word_cnt), 1);
    chk("stall_slot1", 64'(data_out[15:8]), 8'h22);
    chk("stall_acc", 64'(input_acc), 1);
    push_word(8'h02);
    input_rdy = 1'b0; data_in = 8'hEE; tick();
    chk("stall_cnt2", 64'(word_cnt), 2);
    chk("stall_slot2", 64'(data_out[23:16]), 8'h33);
    push_word(8'h03);
    input_rdy = 1'b0; data_in = 8'hEE; tick();
    chk("stall_cnt3", 64'(word_cnt), 3);
    chk("stall_slot3", 64'(data_out[31:24]), 8'h44);
    push_word(8'h04);
    input_rdy = 1'b0;
    repeat (6) begin
      tick();
      chk("park_busy", 64'(busy), 1);
      chk("park_start", 64'(start), 0);
      chk("park_data", 64'(data_out), 32'h04030201);
    end
    chk("park_starts", 64'(start_cnt), 1);
    outsent = 1'b1;
    tick();
    outsent = 1'b0;
    chk("start_after_outsent", 64'(start), 1);

    // Frame 3: outsent seen during LOAD, no wait in WAIT_BUF
    exp_q.push_back(32'hD4C3B2A1);
    push_word(8'hA1); push_word(8'hB2);
    outsent = 1'b1;
    push_word(8'hC3);
    outsent = 1'b0;
    push_word(8'hD4);
    input_rdy = 1'b0;
    chk("f3_release_acc", 64'(input_acc), 0);
    chk("f3_release_start", 64'(start), 0);
    tick();
    chk("f3_waitbuf_start", 64'(start), 0);
    tick();
    chk("f3_start", 64'(start), 1);

    // Frame 4: input_rdy held high 5 cycles in RELEASE
    a0 = acc_cnt;
    exp_q.push_back(32'h8D7C6B5A);
    push_word(8'h5A);
    outsent = 1'b1;
    push_word(8'h6B);
    outsent = 1'b0;
    push_word(8'h7C); push_word(8'h8D);
    data_in = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      chk("rel_acc", 64'(input_acc), 0);
      chk("rel_start", 64'(start), 0);
      chk("rel_cnt", 64'(word_cnt), 0);
      chk("rel_data", 64'(data_out), 32'h8D7C6B5A);
      tick();
    end
    input_rdy = 1'b0;
    chk("rel_still", 64'(start), 0);
    tick();
    chk("f4_waitbuf_start", 64'(start), 0);
    tick();
    chk("f4_start", 64'(start), 1);
    chk("f4_acc_cycles", 64'(acc_cnt - a0), 4);

    // Frame 5: async reset after two words discards the partial frame
    push_word(8'h99); push_word(8'h88);
    chk("pre_rst_cnt", 64'(word_cnt), 2);
    input_rdy = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_data", 64'(data_out), 0);
    chk("async_cnt", 64'(word_cnt), 0);
    chk("async_busy", 64'(busy), 0);
    chk("async_acc", 64'(input_acc), 0);
    chk("async_start", 64'(start), 0);
    tick();
    rst = 1'b1;
    exp_q.push_back(32'h40302010);
    push_word(8'h10);
    chk("restart_slot0", 64'(data_out), 32'h00000010);
    push_word(8'h20); push_word(8'h30); push_word(8'h40);
    input_rdy = 1'b0;
    wait_start();
    repeat (3) tick();
    chk("total_starts", 64'(start_cnt), 5);
    chk("queue_empty", 64'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/param_input_wrapper.md
PARAM_INPUT_WRAPPER -- requirements
Module: param_input_wrapper

Interface
REQ-001 Parameter DW, default 8: width of one input word in bits (1..32).
REQ-002 Parameter NWORDS, default 4: words gathered per frame (2..16).
REQ-003 Parameter WAIT_RELEASE, default 1: 1 = wait for input_rdy low after the last word; 0 = skip that wait.
REQ-004 Derived CW = clog2(NWORDS), minimum 1: width of word_cnt.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, asynchronous assert, active-low (0 = reset), synchronous-release design assumption.
REQ-007 input_rdy  in  1  producer has a valid word on data_in.
REQ-008 data_in  in  DW  input word.
REQ-009 outsent  in  1  downstream has consumed the previous frame (level, any cycle).
REQ-010 input_acc  out  1  wrapper accepts data_in this cycle.
REQ-011 start  out  1  one-cycle pulse: data_out holds a complete frame.
REQ-012 data_out  out  NWORDS*DW  frame buffer; word k at bits [k*DW +: DW].
REQ-013 word_cnt  out  CW  number of words captured in the current frame (0..NWORDS-1 during LOAD).
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 States SHALL be IDLE, LOAD, RELEASE, WAIT_BUF, START; input_acc, start, busy SHALL be decoded from state only (Moore).
REQ-016 IDLE: input_acc=0; on input_rdy=1 go to LOAD next cycle; word_cnt held at 0.
REQ-017 LOAD: input_acc=1; a transfer SHALL occur on each cycle with input_rdy=1 and input_acc=1.
REQ-018 On a transfer, data_in SHALL be written into slot word_cnt of data_out at the clock edge; all other slots unchanged.
REQ-019 On a transfer with word_cnt<NWORDS-1, word_cnt SHALL increment by 1; state stays LOAD.
REQ-020 On a transfer with word_cnt=NWORDS-1, word_cnt SHALL return to 0 and state go to RELEASE (WAIT_RELEASE=1) or WAIT_BUF (WAIT_RELEASE=0).
REQ-021 LOAD with input_rdy=0: stall; no write, word_cnt and state hold, input_acc stays 1.
REQ-022 RELEASE: input_acc=0; stay while input_rdy=1; go to WAIT_BUF on first cycle input_rdy=0.
REQ-023 Internal flag sent_ok SHALL set on any cycle outsent=1 (any state), clear on the cycle state is START, outsent during START SHALL set it (set wins).
REQ-024 WAIT_BUF: go to START on the cycle sent_ok=1 or outsent=1; otherwise hold.
REQ-025 START: start=1 for exactly one cycle, then IDLE unconditionally.
REQ-026 data_out SHALL change only on LOAD transfers; it SHALL be stable from the last transfer through START and until the next frame's first transfer.
REQ-027 Frame latency: with input_rdy high continuously and sent_ok=1, WAIT_RELEASE=0: start asserts NWORDS+2 cycles after the first cycle input_rdy=1 is sampled in IDLE.
REQ-028 input_rdy in RELEASE/WAIT_BUF/START SHALL be ignored; no data captured outside LOAD.
REQ-029 Unused state encodings SHALL return to IDLE on the next clock.

Reset
REQ-030 While rst=0: state=IDLE, word_cnt=0, data_out=0, input_acc=0, start=0, busy=0, sent_ok=1 (downstream initially free).
REQ-031 rst asserted mid-frame SHALL discard partial frame immediately (async), no start pulse generated.
REQ-032 First frame after reset SHALL proceed to START without requiring outsent.

Verification
REQ-033 Defaults, reset, input_rdy held 1, data_in 0x11,0x22,0x33,0x44 on successive LOAD cycles -> data_out=0x44332211, start pulses once, input_acc high exactly 4 cycles.
REQ-034 Stall: input_rdy toggles 1,0,1,0 in LOAD -> only 4 words captured in order, word_cnt holds during low cycles, no duplicate writes.
REQ-035 Second frame, outsent never asserted -> FSM parks in WAIT_BUF, busy=1, data_out unchanged; outsent pulsed 1 cycle -> start next cycle.
REQ-036 outsent pulsed during LOAD of second frame -> no wait in WAIT_BUF, start immediately after RELEASE exit.
REQ-037 WAIT_RELEASE=1, input_rdy kept high 5 cycles after last word -> stays RELEASE 5 cycles, no extra capture, then proceeds.
REQ-038 rst driven 0 after 2 words captured -> outputs reset asynchronously without waiting for clk, data_out=0; frame restarts from slot 0 after release.
